if_stage_gshare: RTL and testbench
==================================

// Module: if_stage_gshare
// PURPOSE
//  Fetch stage with gshare direction predictor, BTB and IF/ID pipeline register. Owns the PC.
//  Consumes stall_pc/stall_if_id from the hazard+forwarding unit and redirect/update from EX.
//  Emits instr, pc and prediction metadata into IF/ID for decode.
// PARAMETERS
//  PHT_IDX_W  8             PHT index width / GHR length (256 x 2-bit counters)
//  BTB_IDX_W  6             BTB index width (64 direct-mapped entries)
//  RESET_PC   32'h0000_0000 PC value after reset
// PORTS
//  i_clk             in  1   clock, all state on rising edge
//  i_reset           in  1   synchronous, active-high reset
//  i_stall_pc        in  1   hold PC (load-use)
//  i_stall_if_id     in  1   hold IF/ID register (load-use)
//  i_redirect_valid  in  1   EX mispredict: load i_redirect_pc, flush IF/ID
//  i_redirect_pc     in  32  correct next PC
//  i_upd_valid       in  1   EX resolved a conditional branch/jump
//  i_upd_pc          in  32  PC of resolved instruction
//  i_upd_taken       in  1   actual outcome
//  i_upd_target      in  32  actual taken target
//  i_upd_ghr         in  PHT_IDX_W  GHR snapshot carried with that instruction
//  o_imem_addr       out 32  = PC; imem read is combinational
//  i_imem_instr      in  32  instruction at o_imem_addr, same cycle
//  o_if_id_valid     out 1   IF/ID holds a real instruction
//  o_if_id_pc        out 32  PC of IF/ID instruction
//  o_if_id_instr     out 32  instruction (NOP when invalid)
//  o_if_id_pred_taken out 1  fetch-time prediction
//  o_if_id_pred_target out 32 predicted next PC (target or pc+4)
//  o_if_id_ghr       out PHT_IDX_W  GHR used for this lookup
// BEHAVIOUR
//  - Reset: PC=RESET_PC, GHR=0, PHT all 2'b01 (weak NT), BTB valid all 0; o_if_id_valid=0,
//    o_if_id_instr=32'h0000_0013, o_if_id_pc=0, pred_taken=0, pred_target=0, o_if_id_ghr=0.
//  - Lookup (comb, on PC): pht_idx = PC[PHT_IDX_W+1:2] ^ GHR; btb_idx = PC[BTB_IDX_W+1:2];
//    hit = btb_valid && tag==PC[31:BTB_IDX_W+2]; pred_taken = hit && pht[idx][1];
//    pred_next = pred_taken ? btb_target : PC+4 (32-bit wrap, no carry out).
//  - Next-PC priority: reset > redirect_valid > stall_pc (hold) > pred_next.
//  - IF/ID priority: reset > redirect_valid (bubble: valid=0, instr=NOP) > stall_if_id (hold)
//    > capture {1, PC, imem_instr, pred_taken, pred_next, GHR}. Redirect beats stall.
//  - GHR: on redirect, GHR <= {i_upd_ghr[PHT_IDX_W-2:0], i_upd_taken} (requires i_upd_valid
//    same cycle; if not, GHR <= i_upd_ghr). Else, when PC advances and hit, GHR shifts in
//    pred_taken. Stall: GHR holds.
//  - Update (i_upd_valid, one-cycle write): idx = i_upd_pc[PHT_IDX_W+1:2] ^ i_upd_ghr;
//    counter +1 if taken, -1 if not, saturating at 2'b00/2'b11. If taken, BTB entry written
//    {valid=1, tag, target}; not-taken never invalidates BTB.
//  - Same-cycle update and lookup of same entry: lookup sees pre-update value (no bypass).
//  - Latency: instruction visible in IF/ID one cycle after PC presented; redirect costs 2
//    bubbles (IF/ID flushed, correct PC fetched next cycle).
//  - Reset mid-operation discards all predictor state and in-flight IF/ID content.
// STRUCTURE
//  - Package pipeline_pkg: NOP_INSTR=32'h0000_0013, counter enc (SNT/WNT/WT/ST),
//    typedef if_id_t {valid, pc, instr, pred_taken, pred_target, ghr}.
//  - Sub-module gshare_predictor: PHT, BTB, GHR, lookup + update; top keeps PC, next-PC
//    mux and IF/ID register.
// TESTING
//  1 Reset then release, no stalls -> o_imem_addr 0,4,8,C; IF/ID valid from 2nd cycle, pc lags 1.
//  2 stall_pc=stall_if_id=1 two cycles at PC=0x10 -> PC, IF/ID, GHR unchanged; resume to 0x14.
//  3 stall + redirect_valid same cycle, redirect_pc=0x200 -> PC=0x200, IF/ID valid=0, instr=NOP.
//  4 Loop branch at 0x40->0x20, four updates taken -> counter reaches 2'b11, BTB hit,
//    next fetch at 0x40 predicts taken, pred_target=0x20, no bubble.
//  5 Counter at 2'b11 updated taken -> stays 2'b11; at 2'b00 updated NT -> stays 2'b00.
//  6 PC=0xFFFF_FFFC, no hit -> next PC 0x0000_0000; reset asserted mid-loop -> all state as reset.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types: NOP encoding, 2-bit counter states and the IF/ID record.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Width of the GHR field carried in the IF/ID record (matches the default PHT index width)
  localparam int unsigned GHR_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [GHR_W-1:0] ghr;
  } if_id_t;

  localparam if_id_t IF_ID_EMPTY = '{
    valid:       1'b0,
    pc:          '0,
    instr:       NOP_INSTR,
    pred_taken:  1'b0,
    pred_target: '0,
    ghr:         '0
  };

  // Saturating 2-bit counter step
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != ST) r = ctr_t'(c + 2'd1);
    end else begin
      if (c != SNT) r = ctr_t'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/gshare_predictor.sv
// Gshare direction predictor with direct-mapped BTB and global history register.
module gshare_predictor
  import pipeline_pkg::*;
#(
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned BTB_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc,
  input  logic                 advance,
  input  logic                 redirect,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic [PHT_IDX_W-1:0] upd_ghr,
  output logic                 pred_taken,
  output logic [31:0]          pred_next,
  output logic [PHT_IDX_W-1:0] ghr
);

  localparam int unsigned TAG_W = 32 - BTB_IDX_W - 2;
  localparam int unsigned PHT_N = 1 << PHT_IDX_W;
  localparam int unsigned BTB_N = 1 << BTB_IDX_W;

  ctr_t             pht        [PHT_N];
  logic             btb_valid  [BTB_N];
  logic [TAG_W-1:0] btb_tag    [BTB_N];
  logic [31:0]      btb_target [BTB_N];

  logic [PHT_IDX_W-1:0] pht_idx;
  logic [BTB_IDX_W-1:0] btb_idx;
  logic [PHT_IDX_W-1:0] upd_pht_idx;
  logic [BTB_IDX_W-1:0] upd_btb_idx;
  logic                 hit;
  logic                 unused_upd_pc_lo;

  // Byte-offset bits of the resolved PC play no part in indexing or tagging
  assign unused_upd_pc_lo = ^upd_pc[1:0];

  // Lookup on the current PC; reads the table contents from before any same-cycle write
  always_comb begin
    pht_idx     = pc[PHT_IDX_W+1:2] ^ ghr;
    btb_idx     = pc[BTB_IDX_W+1:2];
    upd_pht_idx = upd_pc[PHT_IDX_W+1:2] ^ upd_ghr;
    upd_btb_idx = upd_pc[BTB_IDX_W+1:2];
    hit         = btb_valid[btb_idx] && (btb_tag[btb_idx] == pc[31:BTB_IDX_W+2]);
    pred_taken  = hit && pht[pht_idx][1];
    pred_next   = pred_taken ? btb_target[btb_idx] : pc + 32'd4;
  end

  // PHT counters and BTB valid bits: reset to weak-not-taken / empty, trained by EX
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PHT_N; i++) pht[i] <= WNT;
      for (int unsigned i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
    end else if (upd_valid) begin
      pht[upd_pht_idx] <= ctr_next(pht[upd_pht_idx], upd_taken);
      if (upd_taken) btb_valid[upd_btb_idx] <= 1'b1;
    end
  end

  // BTB payload: only meaningful once the valid bit is set, so no reset needed
  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_taken) begin
      btb_tag[upd_btb_idx]    <= upd_pc[31:BTB_IDX_W+2];
      btb_target[upd_btb_idx] <= upd_target;
    end
  end

  // Global history: repaired from EX on redirect, speculatively shifted on a BTB hit
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (redirect) begin
      ghr <= upd_valid ? {upd_ghr[PHT_IDX_W-2:0], upd_taken} : upd_ghr;
    end else if (advance && hit) begin
      ghr <= {ghr[PHT_IDX_W-2:0], pred_taken};
    end
  end

endmodule

// File: rtl/if_stage_gshare.sv
// Fetch stage: owns the PC, selects the next PC and holds the IF/ID pipeline register.
module if_stage_gshare
  import pipeline_pkg::*;
#(
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned BTB_IDX_W = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stall_pc,
  input  logic                 i_stall_if_id,
  input  logic                 i_redirect_valid,
  input  logic [31:0]          i_redirect_pc,
  input  logic                 i_upd_valid,
  input  logic [31:0]          i_upd_pc,
  input  logic                 i_upd_taken,
  input  logic [31:0]          i_upd_target,
  input  logic [PHT_IDX_W-1:0] i_upd_ghr,
  output logic [31:0]          o_imem_addr,
  input  logic [31:0]          i_imem_instr,
  output logic                 o_if_id_valid,
  output logic [31:0]          o_if_id_pc,
  output logic [31:0]          o_if_id_instr,
  output logic                 o_if_id_pred_taken,
  output logic [31:0]          o_if_id_pred_target,
  output logic [PHT_IDX_W-1:0] o_if_id_ghr
);

  logic [31:0]          pc;
  logic                 pred_taken;
  logic [31:0]          pred_next;
  logic [PHT_IDX_W-1:0] ghr;
  if_id_t               if_id;

  gshare_predictor #(
    .PHT_IDX_W (PHT_IDX_W),
    .BTB_IDX_W (BTB_IDX_W)
  ) u_pred (
    .clk        (i_clk),
    .reset      (i_reset),
    .pc         (pc),
    .advance    (!i_stall_pc),
    .redirect   (i_redirect_valid),
    .upd_valid  (i_upd_valid),
    .upd_pc     (i_upd_pc),
    .upd_taken  (i_upd_taken),
    .upd_target (i_upd_target),
    .upd_ghr    (i_upd_ghr),
    .pred_taken (pred_taken),
    .pred_next  (pred_next),
    .ghr        (ghr)
  );

  assign o_imem_addr = pc;

  // PC: redirect beats a load-use hold, otherwise follow the prediction
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      pc <= i_redirect_pc;
    end else if (!i_stall_pc) begin
      pc <= pred_next;
    end
  end

  // IF/ID: flush on redirect (even when stalled), hold on stall, else capture the fetch
  always_ff @(posedge i_clk) begin
    if (i_reset || i_redirect_valid) begin
      if_id <= IF_ID_EMPTY;
    end else if (!i_stall_if_id) begin
      if_id <= '{
        valid:       1'b1,
        pc:          pc,
        instr:       i_imem_instr,
        pred_taken:  pred_taken,
        pred_target: pred_next,
        ghr:         GHR_W'(ghr)
      };
    end
  end

  assign o_if_id_valid       = if_id.valid;
  assign o_if_id_pc          = if_id.pc;
  assign o_if_id_instr       = if_id.instr;
  assign o_if_id_pred_taken  = if_id.pred_taken;
  assign o_if_id_pred_target = if_id.pred_target;
  assign o_if_id_ghr         = PHT_IDX_W'(if_id.ghr);

endmodule

// File: tb/tb_if_stage_gshare.sv
// Scoreboard bench for if_stage_gshare against a behavioural fetch/predictor model.
module tb_if_stage_gshare;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall_pc = 1'b0, stall_if_id = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic [7:0]  upd_ghr = '0;
  logic [31:0] imem_addr, imem_instr;
  logic        if_id_valid, if_id_pred_taken;
  logic [31:0] if_id_pc, if_id_instr, if_id_pred_target;
  logic [7:0]  if_id_ghr;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_instr = imem_f(imem_addr);

  if_stage_gshare #(.PHT_IDX_W(8), .BTB_IDX_W(6), .RESET_PC(32'h0)) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_stall_pc          (stall_pc),
    .i_stall_if_id       (stall_if_id),
    .i_redirect_valid    (redirect_valid),
    .i_redirect_pc       (redirect_pc),
    .i_upd_valid         (upd_valid),
    .i_upd_pc            (upd_pc),
    .i_upd_taken         (upd_taken),
    .i_upd_target        (upd_target),
    .i_upd_ghr           (upd_ghr),
    .o_imem_addr         (imem_addr),
    .i_imem_instr        (imem_instr),
    .o_if_id_valid       (if_id_valid),
    .o_if_id_pc          (if_id_pc),
    .o_if_id_instr       (if_id_instr),
    .o_if_id_pred_taken  (if_id_pred_taken),
    .o_if_id_pred_target (if_id_pred_target),
    .o_if_id_ghr         (if_id_ghr)
  );

  // Reference model state: counters as plain integers, BTB as remembered branch PCs
  logic [31:0] m_pc;
  int          m_ghr;
  int          m_pht [256];
  bit          m_btb_v [64];
  logic [31:0] m_btb_pc [64];
  logic [31:0] m_btb_tgt [64];
  bit          m_v, m_pt;
  logic [31:0] m_ipc, m_instr, m_tgt;
  int          m_ig;

  typedef struct {
    logic [31:0] addr;
    bit          full;
    bit          v;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          pt;
    logic [31:0] tgt;
    int          ghr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances and the expected post-edge state is queued
  task automatic step(input bit rst, input bit sp, input bit si, input bit rv,
                      input logic [31:0] rpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input int ug);
    int          pidx, bidx, uidx;
    bit          hit, pt;
    logic [31:0] pn;
    exp_t        e;
    @(negedge clk);
    #1;
    reset = rst; stall_pc = sp; stall_if_id = si; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt; upd_ghr = 8'(ug);
    e.full = rst;
    if (rst) begin
      m_pc = 32'h0; m_ghr = 0;
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      for (int i = 0; i < 64; i++) m_btb_v[i] = 0;
      m_v = 0; m_ipc = 0; m_instr = NOP_INSTR; m_pt = 0; m_tgt = 0; m_ig = 0;
    end else begin
      pidx = int'((m_pc >> 2) & 32'hFF) ^ m_ghr;
      bidx = int'((m_pc >> 2) & 32'h3F);
      hit  = m_btb_v[bidx] && ((m_btb_pc[bidx] >> 2) == (m_pc >> 2));
      pt   = hit && (m_pht[pidx] >= 2);
      pn   = pt ? m_btb_tgt[bidx] : m_pc + 32'd4;
      if (rv) begin
        m_v = 0; m_instr = NOP_INSTR;
      end else if (!si) begin
        m_v = 1; m_ipc = m_pc; m_instr = imem_f(m_pc); m_pt = pt; m_tgt = pn; m_ig = m_ghr;
      end
      if (rv) m_ghr = uv ? (((ug << 1) | int'(ut)) & 255) : ug;
      else if (!sp && hit) m_ghr = ((m_ghr << 1) | int'(pt)) & 255;
      if (rv) m_pc = rpc;
      else if (!sp) m_pc = pn;
      if (uv) begin
        uidx = int'((upc >> 2) & 32'hFF) ^ ug;
        if (ut) m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
        else    m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
        if (ut) begin
          m_btb_v[(upc >> 2) & 32'h3F]   = 1;
          m_btb_pc[(upc >> 2) & 32'h3F]  = upc;
          m_btb_tgt[(upc >> 2) & 32'h3F] = utgt;
        end
      end
    end
    e.addr = m_pc; e.v = m_v; e.pc = m_ipc; e.instr = m_instr;
    e.pt = m_pt; e.tgt = m_tgt; e.ghr = m_ig;
    q.push_back(e);
  endtask

  task automatic run(input int n, input bit sp = 0, input bit si = 0);
    for (int i = 0; i < n; i++) step(0, sp, si, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic train(input logic [31:0] bpc, input bit taken, input logic [31:0] tgt,
                       input int ug, input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0, 1, bpc, taken, tgt, ug);
  endtask

  task automatic redirect_to(input logic [31:0] rpc, input int ug);
    step(0, 0, 0, 1, rpc, 0, 0, 0, 0, ug);
  endtask

  // Monitor: compare the registered outputs once per cycle, away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check32("imem_addr", imem_addr, e.addr);
        check32("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.v});
        check32("if_id_instr", if_id_instr, e.instr);
        if (e.v || e.full) begin
          check32("if_id_pc", if_id_pc, e.pc);
          check32("if_id_pred_taken", {31'b0, if_id_pred_taken}, {31'b0, e.pt});
          check32("if_id_pred_target", if_id_pred_target, e.tgt);
          check32("if_id_ghr", {24'b0, if_id_ghr}, 32'(e.ghr));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then free-running sequential fetch
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(4);
    // Hold both PC and IF/ID for two cycles at 0x10, then resume
    run(2, 1, 1);
    run(2);
    // Stall and redirect together: redirect wins and flushes IF/ID
    step(0, 1, 1, 1, 32'h200, 0, 0, 0, 0, 0);
    run(3);
    // Loop branch 0x40 -> 0x20 trained four times, then fetched at 0x40
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    train(32'h40, 1, 32'h20, 0, 4);
    redirect_to(32'h40, 0);
    run(12);
    // Saturation at the top, then drive down past zero and climb back
    train(32'h40, 1, 32'h20, 0, 3);
    redirect_to(32'h40, 0);
    run(2);
    train(32'h40, 0, 32'h0, 0, 6);
    redirect_to(32'h40, 0);
    run(2);
    train(32'h40, 1, 32'h20, 0, 1);
    redirect_to(32'h40, 0);
    run(2);
    train(32'h40, 1, 32'h20, 0, 1);
    redirect_to(32'h40, 0);
    run(2);
    // PC wrap at the top of the address space with no BTB entry there
    redirect_to(32'hFFFF_FFFC, 0);
    run(3);
    // Reset in the middle of a predicted loop
    redirect_to(32'h40, 0);
    run(5);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(4);

    // Randomised traffic over a small code window so the BTB and PHT get reused
    for (int i = 0; i < 3000; i++) begin
      bit rst, sp, si, rv, uv, ut;
      int ug;
      rst = ($urandom_range(0, 499) == 0);
      sp  = ($urandom_range(0, 5) == 0);
      si  = ($urandom_range(0, 3) == 0) ? bit'($urandom_range(0, 1)) : sp;
      rv  = ($urandom_range(0, 9) == 0);
      uv  = ($urandom_range(0, 2) == 0);
      ut  = bit'($urandom_range(0, 1));
      ug  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
      step(rst, sp, si, rv, 32'($urandom_range(0, 63)) << 2, uv,
           32'($urandom_range(0, 63)) << 2, ut, 32'($urandom_range(0, 63)) << 2, ug);
    end

    @(negedge clk);
    @(negedge clk);
    check32("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
